// File: rtl/dm_load_unit.sv
// dm_load_unit
// Load unit sitting between the pipeline and a synchronous data-memory core.
// Accepts one load request in IDLE, issues a single read strobe, waits out the
// memory latency, then extracts and extends the addressed byte/half/word and
// holds the result until the consumer acknowledges it.
//
// Optional feature: define LOAD_ADDR_CHECK_EN to enable load address checking
// (misaligned lw/lh/lhu or address >= DM_LIMIT). A faulting load skips the
// memory access and completes at once with exc_adel=1 and rdata=0.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   req        in   1   load request (sampled only in IDLE)
//   addr       in   32  byte address
//   ld_type    in   3   000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, other = lw
//   ack        in   1   consumer accepts result
//   mem_en     out  1   memory read strobe
//   mem_addr   out  11  memory word address
//   mem_rdata  in   32  memory read data (MEM_LAT cycles after mem_en)
//   busy       out  1   not in IDLE
//   valid      out  1   result available
//   rdata      out  32  extended load result
//   exc_adel   out  1   load address error, qualified by valid
module dm_load_unit #(
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] DM_LIMIT = 32'h00002000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [2:0]  ld_type,
  input  logic        ack,
  output logic        mem_en,
  output logic [10:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        exc_adel
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

`ifdef LOAD_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  // Checking disabled: the error term folds to constant 0, exc_adel is tied low.
  localparam bit ADDR_CHECK = 1'b0;
`endif

  // Counter preload; WAIT lasts MEM_LAT cycles (counter MEM_LAT-1 down to 0).
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg;
  logic [12:0] addr_reg;
  logic [2:0]  type_reg;
  logic [31:0] rdata_reg;
  logic        exc_reg;

  logic        is_half;
  logic        is_word;
  logic        addr_err;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext_data;

  // Address check on the incoming request; reserved codes are treated as lw.
  always_comb begin
    is_half  = (ld_type == 3'b001) || (ld_type == 3'b010);
    is_word  = !(ld_type inside {3'b001, 3'b010, 3'b011, 3'b100});
    addr_err = ADDR_CHECK &&
               ((is_word && (addr[1:0] != 2'b00)) ||
                (is_half && addr[0]) ||
                (addr >= DM_LIMIT));
  end

  // Lane selection and extension from the latched address/type.
  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (addr_reg[1:0])
      2'd0: sel_byte = mem_rdata[7:0];
      2'd1: sel_byte = mem_rdata[15:8];
      2'd2: sel_byte = mem_rdata[23:16];
      2'd3: sel_byte = mem_rdata[31:24];
      default: sel_byte = mem_rdata[7:0];
    endcase
    sel_half = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (type_reg)
      3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  ext_data = {16'h0000, sel_half};
      3'b011:  ext_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ext_data = {24'h000000, sel_byte};
      default: ext_data = mem_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (req) state_next = addr_err ? DONE : ISSUE;
      ISSUE: state_next = WAIT;
      WAIT:  if (cnt_reg == 2'd0) state_next = DONE;
      DONE:  if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= 2'd0;
      addr_reg  <= 13'd0;
      type_reg  <= 3'd0;
      rdata_reg <= 32'd0;
      exc_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_reg <= addr[12:0];
            type_reg <= ld_type;
            if (addr_err) begin
              rdata_reg <= 32'd0;
              exc_reg   <= 1'b1;
            end
          end
        end
        ISSUE: cnt_reg <= CNT_INIT;
        WAIT: begin
          if (cnt_reg == 2'd0) begin
            rdata_reg <= ext_data;
            exc_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en   = (state_reg == ISSUE);
  assign mem_addr = addr_reg[12:2];
  assign busy     = (state_reg != IDLE);
  assign valid    = (state_reg == DONE);
  assign rdata    = rdata_reg;
  assign exc_adel = exc_reg;

endmodule

// File: tb/tb_dm_load_unit.sv
module tb_dm_load_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic [2:0]  ld_type;
  logic        ack;
  logic        mem_en;
  logic [10:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        valid;
  logic [31:0] rdata;
  logic        exc_adel;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [2048];
  logic [31:0] pipe [LAT];

  dm_load_unit #(.MEM_LAT(LAT), .DM_LIMIT(32'h00002000)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .ld_type(ld_type),
    .ack(ack), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .valid(valid), .rdata(rdata), .exc_adel(exc_adel)
  );

  always #5 clk = ~clk;

  // Memory core: data appears exactly LAT cycles after the strobe cycle,
  // random garbage on every other cycle.
  always @(posedge clk) begin
    pipe[0] <= mem_en ? mem[mem_addr] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: extension computed arithmetically from the memory word.
  function automatic void model(input logic [31:0] a, input logic [2:0] t,
                                output logic [31:0] r, output logic e);
    logic [31:0] w, b, h;
    logic [2:0]  tt;
    tt = (t > 3'd4) ? 3'd0 : t;
    w  = mem[a[12:2]];
    b  = (w >> (8 * a[1:0])) & 32'hFF;
    h  = (w >> (16 * a[1])) & 32'hFFFF;
    case (tt)
      3'd1:    r = (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd2:    r = h;
      3'd3:    r = (b >= 32'h80) ? b - 32'h100 : b;
      3'd4:    r = b;
      default: r = w;
    endcase
    e = 1'b0;
`ifdef LOAD_ADDR_CHECK_EN
    e = (tt == 3'd0 && (a % 4) != 0) || ((tt == 3'd1 || tt == 3'd2) && (a % 2) != 0) ||
        (a >= 32'h2000);
`endif
    if (e) r = 32'd0;
  endfunction

  // Called at a negedge; returns at the negedge after the ack edge (IDLE).
  task automatic do_load(input logic [31:0] a, input logic [2:0] t, input int hold,
                         input bit stray, output logic [31:0] got_r, output logic got_e);
    logic [31:0] exp_r;
    logic        exp_e;
    int          n_en, lat;
    model(a, t, exp_r, exp_e);
    req = 1'b1; addr = a; ld_type = t;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; addr = $urandom; ld_type = 3'($urandom);
    n_en = 0; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) check("busy_c1", 32'(busy), 32'd1);
      if (mem_en) begin
        n_en++;
        check("mem_addr", 32'(mem_addr), 32'(a[12:2]));
      end
      if (valid) begin lat = c; break; end
      if (stray && c == 2) begin req = 1'b1; ack = 1'b1; end
      if (c == 3) ack = 1'b0;
      @(negedge clk);
    end
    req = 1'b0; ack = 1'b0;
    check("latency", 32'(lat), exp_e ? 32'd1 : 32'(LAT + 2));
    check("mem_en_pulses", 32'(n_en), exp_e ? 32'd0 : 32'd1);
    check("rdata", rdata, exp_r);
    check("exc_adel", 32'(exc_adel), 32'(exp_e));
    got_r = rdata; got_e = exc_adel;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_rdata", rdata, exp_r);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("post_ack_valid", 32'(valid), 32'd0);
    check("post_ack_busy", 32'(busy), 32'd0);
    if (stray) begin
      @(negedge clk);
      check("stray_not_queued", 32'(busy), 32'd0);
    end
    $display("load addr=%h type=%0d rdata=%h exc=%0b lat=%0d", a, t, got_r, got_e, lat);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    reset = 1'b1; req = 1'b0; addr = 32'd0; ld_type = 3'd0; ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_exc", 32'(exc_adel), 32'd0);
    reset = 1'b0;

    // lb sign, lbu lane 2, lhu lane 2 (first req right after reset release)
    mem[4] = 32'h80FF7F01;
    do_load(32'h13, 3'd3, 0, 1'b0, r, e); check("lb_sign", r, 32'hFFFFFF80);
    do_load(32'h12, 3'd4, 0, 1'b0, r, e); check("lbu_lane2", r, 32'h000000FF);
    do_load(32'h12, 3'd2, 0, 1'b0, r, e); check("lhu_lane2", r, 32'h000080FF);
    mem[4] = 32'h1234F00D;
    do_load(32'h10, 3'd1, 0, 1'b0, r, e); check("lh", r, 32'hFFFFF00D);
    do_load(32'h10, 3'd0, 0, 1'b0, r, e); check("lw", r, 32'h1234F00D);
    do_load(32'h10, 3'd6, 0, 1'b0, r, e); check("reserved_as_lw", r, 32'h1234F00D);

    // ack with nothing pending is ignored
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    check("idle_ack_busy", 32'(busy), 32'd0);

    // hold for 5 cycles then back-to-back request right after ack
    do_load(32'h10, 3'd0, 5, 1'b0, r, e);
    do_load(32'h11, 3'd4, 0, 1'b0, r, e); check("b2b_lbu", r, 32'h000000F0);

`ifdef LOAD_ADDR_CHECK_EN
    do_load(32'h2000, 3'd0, 0, 1'b0, r, e); check("err_limit_exc", 32'(e), 32'd1);
    do_load(32'h11, 3'd1, 0, 1'b0, r, e); check("err_lh_exc", 32'(e), 32'd1);
`endif

    // reset while in WAIT abandons the load
    req = 1'b1; addr = 32'h24; ld_type = 3'd4;
    @(posedge clk); @(negedge clk); req = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_valid", 32'(valid), 32'd0);
    check("rst_wait_mem_en", 32'(mem_en), 32'd0);
    check("rst_wait_rdata", rdata, 32'd0);
    check("rst_wait_exc", 32'(exc_adel), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abandoned_valid", 32'(valid), 32'd0);
    end
    do_load(32'h24, 3'd4, 1, 1'b0, r, e);

    // randomized loads against the reference model
    for (int n = 0; n < 40; n++) begin
      do_load($urandom_range(0, 32'h2FFF), 3'($urandom_range(0, 7)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), r, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
